// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - 7-bit address I2C target with byte handshake and SCL stretching
//
// Purpose:
//    Responder end of an I2C bus. It detects START/STOP and matches its own
//    address. Write bytes are shifted in and handed to local logic. Read bytes
//    are requested from local logic and shifted out. ACK/NACK is driven on SDA.
//    SCL is held low while local logic is not ready.
//    Both bus outputs are open-drain style: 0 pulls low, 1 releases.
//
// Ports:
//    clk, rst              system clock, synchronous active-low reset
//    sda_in / sda_out      bus SDA sample / drive (0 = pull low)
//    scl_in / scl_out      bus SCL sample / drive (0 = stretch)
//    rx_dat, rx_vld        written byte and its 1-cycle valid pulse
//    rx_first              qualifies rx_vld: first data byte after the address
//    rx_rdy                local logic can accept a written byte
//    tx_req                1-cycle pulse: a read byte is needed
//    tx_dat, tx_vld        read byte offered by local logic
//    tx_ack                master ACKed the last read byte
//    start_det, stop_det   1-cycle pulses on (repeated) START / STOP
//    busy                  1 while this target is addressed

module i2c_slave #(
   parameter logic [6:0] SLV_ADDR = 7'h50,
   parameter int         HD_DLY   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sda_in,
   output logic       sda_out,
   input  logic       scl_in,
   output logic       scl_out,
   output logic [7:0] rx_dat,
   output logic       rx_vld,
   output logic       rx_first,
   input  logic       rx_rdy,
   output logic       tx_req,
   input  logic [7:0] tx_dat,
   input  logic       tx_vld,
   output logic       tx_ack,
   output logic       start_det,
   output logic       stop_det,
   output logic       busy
);

   localparam logic [3:0] HD = 4'(HD_DLY);

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_HOLD,
      S_WR_ACK, S_TX_WAIT, S_RD_BYTE, S_RD_ACK
   } state_t;

   state_t     state_q, state_d;
   logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_p_q, scl_p_d;
   logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_p_q, sda_p_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       phase_q, phase_d;
   logic       rw_q, rw_d;
   logic       first_q, first_d;
   logic [3:0] hd_cnt_q, hd_cnt_d;
   logic       sda_pend_q, sda_pend_d;
   logic       scl_rel_q, scl_rel_d;
   logic       sda_out_q, sda_out_d;
   logic       scl_out_q, scl_out_d;
   logic [7:0] rx_dat_q, rx_dat_d;
   logic       rx_vld_q, rx_vld_d;
   logic       rx_first_q, rx_first_d;
   logic       tx_req_q, tx_req_d;
   logic       tx_ack_q, tx_ack_d;
   logic       start_det_q, start_det_d;
   logic       stop_det_q, stop_det_d;
   logic       busy_q, busy_d;

   logic scl_rise, scl_fall, start_c, stop_c;

   always_comb begin
      state_d     = state_q;
      scl_s1_d    = scl_in;
      scl_s2_d    = scl_s1_q;
      scl_p_d     = scl_s2_q;
      sda_s1_d    = sda_in;
      sda_s2_d    = sda_s1_q;
      sda_p_d     = sda_s2_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      phase_d     = phase_q;
      rw_d        = rw_q;
      first_d     = first_q;
      hd_cnt_d    = hd_cnt_q;
      sda_pend_d  = sda_pend_q;
      scl_rel_d   = scl_rel_q;
      sda_out_d   = sda_out_q;
      scl_out_d   = scl_out_q;
      rx_dat_d    = rx_dat_q;
      rx_vld_d    = 1'b0;
      rx_first_d  = 1'b0;
      tx_req_d    = 1'b0;
      tx_ack_d    = tx_ack_q;
      start_det_d = 1'b0;
      stop_det_d  = 1'b0;
      busy_d      = busy_q;

      scl_rise = scl_s2_q & ~scl_p_q;
      scl_fall = ~scl_s2_q & scl_p_q;
      // SCL must be stably high across the SDA transition
      start_c  = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
      stop_c   = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;

      // Hold-time timer: a scheduled SDA value lands HD_DLY clk after it was
      // queued; a pending SCL release lands together with it so the bit is
      // already valid when the master sees SCL go high.
      if (hd_cnt_q != 4'd0) begin
         hd_cnt_d = hd_cnt_q - 4'd1;
         if (hd_cnt_q == 4'd1) begin
            sda_out_d = sda_pend_q;
            if (scl_rel_q) begin
               scl_out_d = 1'b1;
               scl_rel_d = 1'b0;
            end
         end
      end

      if (start_c) begin
         state_d     = S_ADDR;
         bit_cnt_d   = 3'd7;
         phase_d     = 1'b0;
         sda_out_d   = 1'b1;
         scl_out_d   = 1'b1;
         hd_cnt_d    = 4'd0;
         scl_rel_d   = 1'b0;
         start_det_d = 1'b1;
      end else if (stop_c) begin
         state_d    = S_IDLE;
         sda_out_d  = 1'b1;
         scl_out_d  = 1'b1;
         hd_cnt_d   = 4'd0;
         scl_rel_d  = 1'b0;
         busy_d     = 1'b0;
         stop_det_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_ADDR: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s2_q};
                  if (bit_cnt_q == 3'd0) begin
                     // shift_q[6:0] holds the 7 address bits, SDA is R/W
                     if (shift_q[6:0] == SLV_ADDR) begin
                        busy_d  = 1'b1;
                        rw_d    = sda_s2_q;
                        phase_d = 1'b0;
                        state_d = S_ADDR_ACK;
                     end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (scl_fall) begin
                  if (!phase_q) begin
                     hd_cnt_d   = HD;
                     sda_pend_d = 1'b0;
                     phase_d    = 1'b1;
                  end else if (!rw_q) begin
                     hd_cnt_d   = HD;
                     sda_pend_d = 1'b1;
                     bit_cnt_d  = 3'd7;
                     first_d    = 1'b1;
                     state_d    = S_WR_BYTE;
                  end else begin
                     tx_req_d  = 1'b1;
                     scl_out_d = 1'b0;
                     state_d   = S_TX_WAIT;
                  end
               end
            end
            S_WR_BYTE: begin
               if (scl_rise) begin
                  shift_d = {shift_q[6:0], sda_s2_q};
                  if (bit_cnt_q == 3'd0) begin
                     phase_d = 1'b0;
                     state_d = S_WR_HOLD;
                  end else begin
                     bit_cnt_d = bit_cnt_q - 3'd1;
                  end
               end
            end
            S_WR_HOLD: begin
               // phase 0: waiting for the 8th-bit fall; phase 1: stretching
               if (!phase_q) begin
                  if (scl_fall) begin
                     if (rx_rdy) begin
                        rx_dat_d   = shift_q;
                        rx_vld_d   = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                        hd_cnt_d   = HD;
                        sda_pend_d = 1'b0;
                        state_d    = S_WR_ACK;
                     end else begin
                        scl_out_d = 1'b0;
                        phase_d   = 1'b1;
                     end
                  end
               end else if (rx_rdy) begin
                  rx_dat_d   = shift_q;
                  rx_vld_d   = 1'b1;
                  rx_first_d = first_q;
                  first_d    = 1'b0;
                  hd_cnt_d   = HD;
                  sda_pend_d = 1'b0;
                  scl_rel_d  = 1'b1;
                  state_d    = S_WR_ACK;
               end
            end
            S_WR_ACK: begin
               if (scl_fall) begin
                  hd_cnt_d   = HD;
                  sda_pend_d = 1'b1;
                  bit_cnt_d  = 3'd7;
                  state_d    = S_WR_BYTE;
               end
            end
            S_TX_WAIT: begin
               // SCL is already held low; it is released together with the MSB
               if (tx_vld) begin
                  shift_d    = {tx_dat[6:0], 1'b0};
                  hd_cnt_d   = HD;
                  sda_pend_d = tx_dat[7];
                  scl_rel_d  = 1'b1;
                  bit_cnt_d  = 3'd7;
                  state_d    = S_RD_BYTE;
               end
            end
            S_RD_BYTE: begin
               // bit_cnt is the index of the bit currently on the bus
               if (scl_fall) begin
                  hd_cnt_d = HD;
                  if (bit_cnt_q == 3'd0) begin
                     sda_pend_d = 1'b1;
                     state_d    = S_RD_ACK;
                  end else begin
                     sda_pend_d = shift_q[7];
                     shift_d    = {shift_q[6:0], 1'b0};
                     bit_cnt_d  = bit_cnt_q - 3'd1;
                  end
               end
            end
            S_RD_ACK: begin
               if (scl_rise) begin
                  tx_ack_d = ~sda_s2_q;
               end
               if (scl_fall) begin
                  if (tx_ack_q) begin
                     tx_req_d  = 1'b1;
                     scl_out_d = 1'b0;
                     state_d   = S_TX_WAIT;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         scl_s1_q    <= 1'b1;
         scl_s2_q    <= 1'b1;
         scl_p_q     <= 1'b1;
         sda_s1_q    <= 1'b1;
         sda_s2_q    <= 1'b1;
         sda_p_q     <= 1'b1;
         bit_cnt_q   <= 3'd7;
         shift_q     <= 8'd0;
         phase_q     <= 1'b0;
         rw_q        <= 1'b0;
         first_q     <= 1'b0;
         hd_cnt_q    <= 4'd0;
         sda_pend_q  <= 1'b1;
         scl_rel_q   <= 1'b0;
         sda_out_q   <= 1'b1;
         scl_out_q   <= 1'b1;
         rx_dat_q    <= 8'd0;
         rx_vld_q    <= 1'b0;
         rx_first_q  <= 1'b0;
         tx_req_q    <= 1'b0;
         tx_ack_q    <= 1'b0;
         start_det_q <= 1'b0;
         stop_det_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         scl_s1_q    <= scl_s1_d;
         scl_s2_q    <= scl_s2_d;
         scl_p_q     <= scl_p_d;
         sda_s1_q    <= sda_s1_d;
         sda_s2_q    <= sda_s2_d;
         sda_p_q     <= sda_p_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         phase_q     <= phase_d;
         rw_q        <= rw_d;
         first_q     <= first_d;
         hd_cnt_q    <= hd_cnt_d;
         sda_pend_q  <= sda_pend_d;
         scl_rel_q   <= scl_rel_d;
         sda_out_q   <= sda_out_d;
         scl_out_q   <= scl_out_d;
         rx_dat_q    <= rx_dat_d;
         rx_vld_q    <= rx_vld_d;
         rx_first_q  <= rx_first_d;
         tx_req_q    <= tx_req_d;
         tx_ack_q    <= tx_ack_d;
         start_det_q <= start_det_d;
         stop_det_q  <= stop_det_d;
         busy_q      <= busy_d;
      end
   end

   assign sda_out   = sda_out_q;
   assign scl_out   = scl_out_q;
   assign rx_dat    = rx_dat_q;
   assign rx_vld    = rx_vld_q;
   assign rx_first  = rx_first_q;
   assign tx_req    = tx_req_q;
   assign tx_ack    = tx_ack_q;
   assign start_det = start_det_q;
   assign stop_det  = stop_det_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed bus-master bench for i2c_slave

module tb_i2c_slave;

   localparam int HALF = 20;

   logic       clk;
   logic       rst;
   logic       sda_m, scl_m;
   logic       rx_rdy;
   logic [7:0] tx_dat;
   logic       tx_vld;
   logic       sda_out, scl_out;
   logic [7:0] rx_dat;
   logic       rx_vld, rx_first, tx_req, tx_ack, start_det, stop_det, busy;
   wire        sda_line = sda_m & sda_out;
   wire        scl_line = scl_m & scl_out;

   int checks = 0;
   int errors = 0;
   int n_start = 0, n_stop = 0, n_rx = 0, n_tx = 0, n_low = 0;
   logic [31:0] exp_rx[$];
   logic [31:0] exp_rd[$];

   i2c_slave #(.SLV_ADDR(7'h50), .HD_DLY(4)) dut (
      .clk(clk), .rst(rst), .sda_in(sda_line), .sda_out(sda_out),
      .scl_in(scl_line), .scl_out(scl_out), .rx_dat(rx_dat), .rx_vld(rx_vld),
      .rx_first(rx_first), .rx_rdy(rx_rdy), .tx_req(tx_req), .tx_dat(tx_dat),
      .tx_vld(tx_vld), .tx_ack(tx_ack), .start_det(start_det),
      .stop_det(stop_det), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scl_high();
      scl_m = 1'b1;
      for (int i = 0; i < 3000 && scl_line !== 1'b1; i++) @(negedge clk);
      check("scl_release", 32'(scl_line), 32'd1);
   endtask

   task automatic clock_bit(input logic b, output logic s);
      sda_m = b;
      wait_clk(HALF);
      scl_high();
      wait_clk(HALF);
      s = sda_line;
      scl_m = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic send_start();
      sda_m = 1'b1;
      wait_clk(HALF);
      scl_high();
      wait_clk(HALF);
      sda_m = 1'b0;
      wait_clk(HALF);
      scl_m = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic send_stop();
      sda_m = 1'b0;
      wait_clk(HALF);
      scl_high();
      wait_clk(HALF);
      sda_m = 1'b1;
      wait_clk(HALF);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
      clock_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         d[i] = s;
      end
      clock_bit(~mack, s);
   endtask

   task automatic check_rd(input logic [7:0] d);
      logic [31:0] e;
      e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hFFFF_FFFF;
      check("rd_byte", 32'(d), e);
   endtask

   task automatic serve_tx(input logic [7:0] d, input int dly, output int held);
      int n;
      n = 0;
      held = 0;
      while (tx_req !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("tx_req_seen", 32'(tx_req), 32'd1);
      exp_rd.push_back(32'(d));
      repeat (dly) begin
         if (scl_out === 1'b0) held++;
         @(negedge clk);
      end
      tx_dat = d;
      tx_vld = 1'b1;
      @(negedge clk);
      tx_vld = 1'b0;
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      int         h, cnt, n;
      int         b_start, b_stop, b_rx, b_tx, b_low;

      rst = 1'b0; sda_m = 1'b1; scl_m = 1'b1;
      rx_rdy = 1'b1; tx_dat = 8'h00; tx_vld = 1'b0;

      fork
         forever begin : mon
            logic [31:0] e;
            @(negedge clk);
            if (rst) begin
               if (start_det) n_start++;
               if (stop_det) n_stop++;
               if (tx_req) n_tx++;
               if (sda_out === 1'b0) n_low++;
               if (rx_vld) begin
                  n_rx++;
                  e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 32'hFFFF_FFFF;
                  check("rx_byte", {23'd0, rx_first, rx_dat}, e);
               end
            end
         end
      join_none

      wait_clk(5);
      check("rst_sda", 32'(sda_out), 32'd1);
      check("rst_scl", 32'(scl_out), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rx_dat", 32'(rx_dat), 32'd0);
      check("rst_pulses", {26'd0, rx_vld, tx_req, tx_ack, start_det, stop_det, rx_first}, 32'd0);
      rst = 1'b1;
      wait_clk(10);

      // plain write 0x50+W, 0xA5
      b_start = n_start; b_stop = n_stop; b_rx = n_rx;
      send_start();
      write_byte(8'hA0, ack);
      check("wr_addr_ack", 32'(ack), 32'd1);
      check("wr_busy", 32'(busy), 32'd1);
      exp_rx.push_back(32'h1A5);
      write_byte(8'hA5, ack);
      check("wr_data_ack", 32'(ack), 32'd1);
      send_stop();
      wait_clk(10);
      check("wr_busy_end", 32'(busy), 32'd0);
      check("wr_start_cnt", n_start - b_start, 1);
      check("wr_stop_cnt", n_stop - b_stop, 1);
      check("wr_rx_cnt", n_rx - b_rx, 1);

      // foreign address 0x51
      b_stop = n_stop; b_rx = n_rx; b_low = n_low;
      send_start();
      write_byte(8'hA2, ack);
      check("na_addr_ack", 32'(ack), 32'd0);
      check("na_busy", 32'(busy), 32'd0);
      write_byte(8'h5A, ack);
      check("na_data_ack", 32'(ack), 32'd0);
      send_stop();
      wait_clk(10);
      check("na_sda_low", n_low - b_low, 0);
      check("na_rx_cnt", n_rx - b_rx, 0);
      check("na_stop_cnt", n_stop - b_stop, 1);

      // read two bytes: ACK then NACK
      b_tx = n_tx;
      fork
         begin
            send_start();
            write_byte(8'hA1, ack);
            check("rd_addr_ack", 32'(ack), 32'd1);
            read_byte(1'b1, d);
            check_rd(d);
            check("rd_tx_ack1", 32'(tx_ack), 32'd1);
            read_byte(1'b0, d);
            check_rd(d);
            check("rd_tx_ack0", 32'(tx_ack), 32'd0);
            check("rd_busy_nack", 32'(busy), 32'd0);
            send_stop();
         end
         begin
            serve_tx(8'h3C, 0, h);
            serve_tx(8'hC3, 0, h);
         end
      join
      check("rd_tx_req_cnt", n_tx - b_tx, 2);

      // stretched write then stretched read
      rx_rdy = 1'b0;
      fork
         begin
            send_start();
            write_byte(8'hA0, ack);
            check("sw_addr_ack", 32'(ack), 32'd1);
            exp_rx.push_back(32'h177);
            write_byte(8'h77, ack);
            check("sw_data_ack", 32'(ack), 32'd1);
            send_stop();
         end
         begin
            n = 0;
            while (scl_out !== 1'b0 && n < 20000) begin
               @(negedge clk);
               n++;
            end
            cnt = 0;
            repeat (200) begin
               if (scl_out === 1'b0) cnt++;
               @(negedge clk);
            end
            rx_rdy = 1'b1;
            check("wr_stretch", cnt, 200);
         end
      join
      fork
         begin
            send_start();
            write_byte(8'hA1, ack);
            check("sr_addr_ack", 32'(ack), 32'd1);
            read_byte(1'b0, d);
            check_rd(d);
            send_stop();
         end
         begin
            serve_tx(8'h96, 150, h);
            check("rd_stretch", h, 150);
         end
      join

      // repeated START after 4 data bits
      b_start = n_start; b_rx = n_rx;
      fork
         begin
            send_start();
            write_byte(8'hA0, ack);
            check("rs_addr_ack", 32'(ack), 32'd1);
            clock_bit(1'b1, ack);
            clock_bit(1'b0, ack);
            clock_bit(1'b1, ack);
            clock_bit(1'b0, ack);
            send_start();
            write_byte(8'hA1, ack);
            check("rs_raddr_ack", 32'(ack), 32'd1);
            read_byte(1'b0, d);
            check_rd(d);
            send_stop();
         end
         begin
            serve_tx(8'h5A, 0, h);
         end
      join
      wait_clk(10);
      check("rs_rx_cnt", n_rx - b_rx, 0);
      check("rs_start_cnt", n_start - b_start, 2);

      // reset pulse while driving a 0 data bit
      fork
         begin
            send_start();
            write_byte(8'hA1, ack);
            read_byte(1'b1, d);
         end
         begin
            serve_tx(8'h00, 0, h);
            n = 0;
            while (sda_out !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
            while (scl_line !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
            while (scl_line !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
            wait_clk(12);
            check("mid_sda_low", 32'(sda_out), 32'd0);
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            check("mr_sda", 32'(sda_out), 32'd1);
            check("mr_scl", 32'(scl_out), 32'd1);
            check("mr_busy", 32'(busy), 32'd0);
         end
      join
      exp_rd.delete();
      send_stop();
      b_rx = n_rx;
      send_start();
      write_byte(8'hA0, ack);
      check("ar_addr_ack", 32'(ack), 32'd1);
      exp_rx.push_back(32'h13C);
      write_byte(8'h3C, ack);
      check("ar_data_ack", 32'(ack), 32'd1);
      send_stop();
      wait_clk(10);
      check("ar_rx_cnt", n_rx - b_rx, 1);
      check("ar_busy", 32'(busy), 32'd0);
      check("rx_queue_left", exp_rx.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- 7-bit-address I2C target for the same bus that i2c_master drives. Provides the responder end of the protocol: detects START/STOP and address match, shifts write bytes in, shifts read bytes out, and generates ACK/NACK.
- Presents a byte-level handshake to local logic.
- Stretches SCL whenever local logic is not ready.
- Open-drain style: sda_out/scl_out = 0 pulls low, 1 releases.

Parameters:
SLV_ADDR, 7'h50, own 7-bit address
HD_DLY, 4, clk cycles from synchronized SCL fall to SDA change (tHD;DAT); range 1..15

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (0 = reset)
sda_in  in  1  bus SDA
sda_out  out  1  SDA drive, 0 = pull low
scl_in  in  1  bus SCL
scl_out  out  1  SCL drive, 0 = stretch
rx_dat  out  8  last byte written by master
rx_vld  out  1  1-cycle pulse: rx_dat valid
rx_first  out  1  qualifies rx_vld: first data byte after address
rx_rdy  in  1  local logic can accept a byte
tx_req  out  1  1-cycle pulse: byte needed for read
tx_dat  in  8  read byte
tx_vld  in  1  tx_dat valid; sampled while waiting after tx_req
tx_ack  out  1  master ACKed last read byte (valid from RD_ACK until next tx_req)
start_det  out  1  1-cycle pulse on START or repeated START
stop_det  out  1  1-cycle pulse on STOP
busy  out  1  1 while addressed (address match until STOP/NACKed read/non-matching START)

Behaviour:
- Reset (rst=0 at posedge clk): sda_out=1, scl_out=1, all pulses 0, rx_dat=0, tx_ack=0, busy=0, state=IDLE, synchronizers=1.
- SCL/SDA pass through 2-flop synchronizers, plus a previous-value register. Edges are detected on synchronized values; latency from pin to edge is 3 clk.
- START: SDA fall while SCL high.
  - From any state, including mid-byte: go to ADDR, bit counter=7, release sda_out and scl_out, pulse start_det.
- STOP: SDA rise while SCL high.
  - From any state: go to IDLE, release both lines, busy=0, pulse stop_det.
  - START/STOP take priority over any bit event in the same cycle.
- Bits are sampled on the synchronized SCL rising edge, MSB first.
- sda_out changes only HD_DLY clk after the synchronized SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - bits[7:1]==SLV_ADDR: ADDR_ACK, busy=1.
    - Otherwise: IDLE, no ACK driven.
  - ADDR_ACK: drive 0 for the ACK bit.
    - R/W=0: release after the ACK clock, go to WR_BYTE.
    - R/W=1: pulse tx_req at the SCL fall ending ACK, then TX_WAIT.
  - WR_BYTE: shift 8 bits; at the 8th rise go to WR_HOLD.
  - WR_HOLD: on the SCL fall, hold scl_out=0 until rx_rdy=1.
    - Then load rx_dat and pulse rx_vld (rx_first=1 only for the first byte since the address).
    - Drive sda_out=0 (ACK) after HD_DLY, release SCL, go to WR_ACK.
    - If rx_rdy=1 already at the fall, no stretch.
  - WR_ACK: after the ACK clock fall, release SDA (HD_DLY later), go to WR_BYTE.
  - TX_WAIT: scl_out=0 until tx_vld=1.
    - Then latch tx_dat, drive MSB after HD_DLY, release SCL, go to RD_BYTE.
    - If tx_vld=1 in the same cycle as tx_req, no stretch beyond HD_DLY.
  - RD_BYTE: drive the next bit after each fall; after the 8th bit's fall, release SDA, go to RD_ACK.
  - RD_ACK: sample master ACK at the SCL rise; tx_ack = ~SDA.
    - ACK: pulse tx_req at the fall, go to TX_WAIT.
    - NACK: IDLE, busy=0, SDA released.
- Bit counter is 3-bit and wraps 0→7 only on byte reload.
- Arbitration: target never checks SDA readback.
- Reset mid-transfer releases both lines in the same cycle.

Test Plan:
- START, addr 0x50+W, data 0xA5, STOP, rx_rdy=1 → ACK on both bytes. rx_vld once with rx_dat=0xA5, rx_first=1. start_det and stop_det each pulse once. busy 1→0.
- START, addr 0x51+W → sda_out stays 1 for the whole transfer, no rx_vld, busy=0. stop_det still pulses on STOP.
- START, 0x50+R, tx_dat 0x3C then 0xC3, master ACK then NACK → bus reads 0x3C, 0xC3. tx_req pulses twice, tx_ack 1 then 0, final state IDLE.
- Write with rx_rdy=0 for 200 clk after the 8th bit, and read with tx_vld delayed 150 clk → scl_out held 0 for ≥200/≥150 clk. Data intact, ACK driven after release.
- Repeated START after 4 data bits, then 0x50+R → partial byte discarded (no rx_vld). start_det pulses, read proceeds correctly.
- Assert rst=0 for 1 clk mid read-byte with sda_out=0 → next cycle sda_out=1, scl_out=1, busy=0. Next START/address is handled normally.
